piece_cell_probe: RTL and testbench

//  Sequential successor to the combinational current-piece cell calculator, with parametrised board size.

---
 rtl/piece_cell_probe.sv | 278 +++++++++++++++++++++++++++
 tb/tb_piece_cell_probe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/piece_cell_probe.sv
// piece_cell_probe
//   Sequential current-piece cell calculator. A request (piece, pos_x, pos_y,
//   rot) is latched, the four board cell indices and the bounding box size are
//   computed, bounds are checked, and every in-bounds cell is read from the
//   board RAM to detect a collision.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid / req_ready      request handshake (req_ready only in IDLE)
//   piece, pos_x, pos_y, rot   request payload
//   brd_rd_en / brd_rd_addr    board read strobe and cell index
//   brd_rd_data                board read data, one cycle after brd_rd_en
//   resp_valid / resp_ready    response handshake (response held until taken)
//   blk_1..blk_4               cell indices, ERR_BLK_POS when off the board
//   width, height              bounding box size
//   in_bounds                  all four cells on the board
//   collide                    any cell occupied (meaningful when in_bounds=1)

`ifndef BITS_PER_BLOCK
`define BITS_PER_BLOCK 3
`endif
`ifndef EMPTY_BLOCK
`define EMPTY_BLOCK 3'd0
`endif
`ifndef I_BLOCK
`define I_BLOCK 3'd1
`endif
`ifndef O_BLOCK
`define O_BLOCK 3'd2
`endif
`ifndef T_BLOCK
`define T_BLOCK 3'd3
`endif
`ifndef S_BLOCK
`define S_BLOCK 3'd4
`endif
`ifndef Z_BLOCK
`define Z_BLOCK 3'd5
`endif
`ifndef J_BLOCK
`define J_BLOCK 3'd6
`endif
`ifndef L_BLOCK
`define L_BLOCK 3'd7
`endif
`ifndef ERR_BLK_POS
`define ERR_BLK_POS 8'd255
`endif

module piece_cell_probe #(
  parameter int BLOCKS_WIDE = 10,
  parameter int BLOCKS_HIGH = 20,
  parameter int X_W         = 4,
  parameter int Y_W         = 5,
  parameter int IDX_W       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [`BITS_PER_BLOCK-1:0] piece,
  input  logic [X_W-1:0]             pos_x,
  input  logic [Y_W-1:0]             pos_y,
  input  logic [1:0]                 rot,
  output logic                       brd_rd_en,
  output logic [IDX_W-1:0]           brd_rd_addr,
  input  logic                       brd_rd_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [IDX_W-1:0]           blk_1,
  output logic [IDX_W-1:0]           blk_2,
  output logic [IDX_W-1:0]           blk_3,
  output logic [IDX_W-1:0]           blk_4,
  output logic [2:0]                 width,
  output logic [2:0]                 height,
  output logic                       in_bounds,
  output logic                       collide
);

  localparam int XE = X_W + 2;
  localparam int YE = Y_W + 2;
  localparam logic [IDX_W-1:0] ERR = IDX_W'(`ERR_BLK_POS);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_RD0, S_RD1, S_RD2, S_RD3, S_LAST, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [`BITS_PER_BLOCK-1:0] piece_q;
  logic [X_W-1:0]             x_q;
  logic [Y_W-1:0]             y_q;
  logic [1:0]                 rot_q;

  // Shape decode: per cell {dx[1:0], dy[1:0]}, blk_1 in the top nibble.
  logic [15:0] shp;
  logic [2:0]  sw, sh;
  logic        known;

  logic [XE-1:0]    cx   [4];
  logic [YE-1:0]    cy   [4];
  logic [IDX_W-1:0] cidx [4];
  logic             all_in;

  assign req_ready = (state == S_IDLE) && rst_n;

  // Offset table and bounding box for the latched piece/rotation
  always_comb begin
    shp   = 16'd0;
    sw    = 3'd0;
    sh    = 3'd0;
    known = 1'b1;
    case (piece_q)
      `I_BLOCK: begin
        if (rot_q[0]) begin
          shp = {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd3,2'd0}; sw = 3'd4; sh = 3'd1;
        end else begin
          shp = {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd0,2'd3}; sw = 3'd1; sh = 3'd4;
        end
      end
      `O_BLOCK: begin
        shp = {2'd0,2'd0, 2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1}; sw = 3'd2; sh = 3'd2;
      end
      `T_BLOCK: begin
        case (rot_q)
          2'd0:    begin shp = {2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1}; sw = 3'd3; sh = 3'd2; end
          2'd1:    begin shp = {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd1}; sw = 3'd2; sh = 3'd3; end
          2'd2:    begin shp = {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd1,2'd1}; sw = 3'd3; sh = 3'd2; end
          default: begin shp = {2'd1,2'd0, 2'd1,2'd1, 2'd1,2'd2, 2'd0,2'd1}; sw = 3'd2; sh = 3'd3; end
        endcase
      end
      `S_BLOCK: begin
        if (rot_q[0]) begin
          shp = {2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd1,2'd2}; sw = 3'd2; sh = 3'd3;
        end else begin
          shp = {2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1}; sw = 3'd3; sh = 3'd2;
        end
      end
      `Z_BLOCK: begin
        if (rot_q[0]) begin
          shp = {2'd1,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd1}; sw = 3'd2; sh = 3'd3;
        end else begin
          shp = {2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd2,2'd1}; sw = 3'd3; sh = 3'd2;
        end
      end
      `J_BLOCK: begin
        case (rot_q)
          2'd0:    begin shp = {2'd1,2'd0, 2'd1,2'd1, 2'd1,2'd2, 2'd0,2'd2}; sw = 3'd2; sh = 3'd3; end
          2'd1:    begin shp = {2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1}; sw = 3'd3; sh = 3'd2; end
          2'd2:    begin shp = {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd0}; sw = 3'd2; sh = 3'd3; end
          default: begin shp = {2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd2,2'd1}; sw = 3'd3; sh = 3'd2; end
        endcase
      end
      `L_BLOCK: begin
        case (rot_q)
          2'd0:    begin shp = {2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd2}; sw = 3'd2; sh = 3'd3; end
          2'd1:    begin shp = {2'd0,2'd1, 2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0}; sw = 3'd3; sh = 3'd2; end
          2'd2:    begin shp = {2'd1,2'd0, 2'd1,2'd1, 2'd1,2'd2, 2'd0,2'd0}; sw = 3'd2; sh = 3'd3; end
          default: begin shp = {2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1, 2'd2,2'd0}; sw = 3'd3; sh = 3'd2; end
        endcase
      end
      default: known = 1'b0;  // EMPTY and any unassigned code
    endcase
  end

  // Cell coordinates widened by two bits so pos+offset never wraps
  always_comb begin
    all_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cx[k] = {2'b00, x_q} + XE'(shp[4*(3-k)+3 -: 2]);
      cy[k] = {2'b00, y_q} + YE'(shp[4*(3-k)+1 -: 2]);
      if ((cx[k] >= XE'(BLOCKS_WIDE)) || (cy[k] >= YE'(BLOCKS_HIGH))) begin
        cidx[k] = ERR;
        all_in  = 1'b0;
      end else begin
        cidx[k] = IDX_W'(cy[k]) * IDX_W'(BLOCKS_WIDE) + IDX_W'(cx[k]);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nx = S_CALC;
        else           state_nx = S_IDLE;
      end
      S_CALC: begin
        if (known && all_in) state_nx = S_RD0;
        else                 state_nx = S_DONE;
      end
      S_RD0:  state_nx = S_RD1;
      S_RD1:  state_nx = S_RD2;
      S_RD2:  state_nx = S_RD3;
      S_RD3:  state_nx = S_LAST;
      S_LAST: state_nx = S_DONE;
      S_DONE: begin
        if (resp_ready) state_nx = S_IDLE;
        else            state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, result registers, read strobe and response valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      piece_q     <= `BITS_PER_BLOCK'(0);
      x_q         <= {X_W{1'b0}};
      y_q         <= {Y_W{1'b0}};
      rot_q       <= 2'd0;
      blk_1       <= ERR;
      blk_2       <= ERR;
      blk_3       <= ERR;
      blk_4       <= ERR;
      width       <= 3'd0;
      height      <= 3'd0;
      in_bounds   <= 1'b0;
      collide     <= 1'b0;
      brd_rd_en   <= 1'b0;
      brd_rd_addr <= {IDX_W{1'b0}};
      resp_valid  <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        piece_q <= piece;
        x_q     <= pos_x;
        y_q     <= pos_y;
        rot_q   <= rot;
      end

      if (state == S_CALC) begin
        collide <= 1'b0;
        if (known) begin
          blk_1     <= cidx[0];
          blk_2     <= cidx[1];
          blk_3     <= cidx[2];
          blk_4     <= cidx[3];
          width     <= sw;
          height    <= sh;
          in_bounds <= all_in;
        end else begin
          blk_1     <= ERR;
          blk_2     <= ERR;
          blk_3     <= ERR;
          blk_4     <= ERR;
          width     <= 3'd0;
          height    <= 3'd0;
          in_bounds <= 1'b1;
        end
      end else if (state == S_RD1 || state == S_RD2 || state == S_RD3 || state == S_LAST) begin
        // Each of these states sees the data of the read issued one cycle earlier.
        collide <= collide | brd_rd_data;
      end

      // blk_1 is not registered yet when entering RD0, so use the live index.
      case (state_nx)
        S_RD0:   begin brd_rd_en <= 1'b1; brd_rd_addr <= cidx[0]; end
        S_RD1:   begin brd_rd_en <= 1'b1; brd_rd_addr <= blk_2;   end
        S_RD2:   begin brd_rd_en <= 1'b1; brd_rd_addr <= blk_3;   end
        S_RD3:   begin brd_rd_en <= 1'b1; brd_rd_addr <= blk_4;   end
        default: begin brd_rd_en <= 1'b0; brd_rd_addr <= {IDX_W{1'b0}}; end
      endcase

      resp_valid <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_piece_cell_probe.sv
// Randomized self-checking bench for piece_cell_probe. A board array and a
// shape table built from the piece definitions feed a reference model that
// derives indices, bounding box, bounds and collision arithmetically.

module tb_piece_cell_probe;

  localparam int W   = 10;
  localparam int H   = 20;
  localparam int ERR = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] piece = 3'd0;
  logic [3:0] pos_x = 4'd0;
  logic [4:0] pos_y = 5'd0;
  logic [1:0] rot = 2'd0;
  logic       brd_rd_en;
  logic [7:0] brd_rd_addr;
  logic       brd_rd_data = 1'b0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] blk_1, blk_2, blk_3, blk_4;
  logic [2:0] width, height;
  logic       in_bounds, collide;

  int checks = 0;
  int errors = 0;

  bit board [W*H];
  int sh [8][4][8];

  int exp_blk [4];
  int exp_w, exp_h, exp_inb, exp_col, exp_reads, exp_lat;

  piece_cell_probe dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .piece(piece), .pos_x(pos_x), .pos_y(pos_y), .rot(rot),
    .brd_rd_en(brd_rd_en), .brd_rd_addr(brd_rd_addr), .brd_rd_data(brd_rd_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .blk_1(blk_1), .blk_2(blk_2), .blk_3(blk_3), .blk_4(blk_4),
    .width(width), .height(height), .in_bounds(in_bounds), .collide(collide)
  );

  always #5 clk = ~clk;

  // Board RAM: one-cycle read latency; junk on the data line when not reading.
  always @(posedge clk) begin
    if (brd_rd_en && brd_rd_addr < W*H) brd_rd_data <= board[brd_rd_addr];
    else                                brd_rd_data <= 1'($urandom);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic build_shapes();
    sh[1][0] = '{0,0, 0,1, 0,2, 0,3};  sh[1][1] = '{0,0, 1,0, 2,0, 3,0};
    sh[2][0] = '{0,0, 1,0, 0,1, 1,1};
    sh[3][0] = '{1,0, 0,1, 1,1, 2,1};  sh[3][1] = '{0,0, 0,1, 0,2, 1,1};
    sh[3][2] = '{0,0, 1,0, 2,0, 1,1};  sh[3][3] = '{1,0, 1,1, 1,2, 0,1};
    sh[4][0] = '{1,0, 2,0, 0,1, 1,1};  sh[4][1] = '{0,0, 0,1, 1,1, 1,2};
    sh[5][0] = '{0,0, 1,0, 1,1, 2,1};  sh[5][1] = '{1,0, 0,1, 0,2, 1,1};
    sh[6][0] = '{1,0, 1,1, 1,2, 0,2};  sh[6][1] = '{0,0, 0,1, 1,1, 2,1};
    sh[6][2] = '{0,0, 0,1, 0,2, 1,0};  sh[6][3] = '{0,0, 1,0, 2,0, 2,1};
    sh[7][0] = '{0,0, 0,1, 0,2, 1,2};  sh[7][1] = '{0,1, 0,0, 1,0, 2,0};
    sh[7][2] = '{1,0, 1,1, 1,2, 0,0};  sh[7][3] = '{0,1, 1,1, 2,1, 2,0};
    sh[2][1] = sh[2][0]; sh[2][2] = sh[2][0]; sh[2][3] = sh[2][0];
    sh[1][2] = sh[1][0]; sh[1][3] = sh[1][1];
    sh[4][2] = sh[4][0]; sh[4][3] = sh[4][1];
    sh[5][2] = sh[5][0]; sh[5][3] = sh[5][1];
  endtask

  task automatic model(input int p, input int x, input int y, input int r);
    int mx, my, cx, cy, hit;
    mx = 0; my = 0; hit = 0;
    exp_inb = 1;
    if (p < 1 || p > 7) begin
      for (int k = 0; k < 4; k++) exp_blk[k] = ERR;
      exp_w = 0; exp_h = 0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        cx = x + sh[p][r][2*k];
        cy = y + sh[p][r][2*k+1];
        if (sh[p][r][2*k]   > mx) mx = sh[p][r][2*k];
        if (sh[p][r][2*k+1] > my) my = sh[p][r][2*k+1];
        if (cx >= W || cy >= H) begin
          exp_blk[k] = ERR;
          exp_inb = 0;
        end else begin
          exp_blk[k] = cy*W + cx;
          if (board[cy*W + cx]) hit = 1;
        end
      end
      exp_w = mx + 1; exp_h = my + 1;
    end
    exp_reads = (p >= 1 && p <= 7 && exp_inb == 1) ? 1 : 0;
    exp_col   = exp_reads ? hit : 0;
    exp_lat   = exp_reads ? 7 : 2;
  endtask

  // Starts right after a falling edge with the DUT idle; returns the same way.
  task automatic do_req(input int p, input int x, input int y, input int r, input int hold);
    int n, got_lat;
    logic [63:0] saved;
    model(p, x, y, r);
    check("req_ready_idle", req_ready, 1);
    piece = 3'(p); pos_x = 4'(x); pos_y = 5'(y); rot = 2'(r);
    req_valid = 1'b1;
    @(posedge clk);
    n = 0; got_lat = 0;
    while (got_lat == 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        piece = 3'($urandom); pos_x = 4'($urandom); pos_y = 5'($urandom); rot = 2'($urandom);
        check("req_ready_busy", req_ready, 0);
      end
      if (n >= 2 && n <= 5 && exp_reads == 1) begin
        check("rd_en", brd_rd_en, 1);
        check("rd_addr", brd_rd_addr, exp_blk[n-2]);
      end else begin
        check("rd_en_idle", brd_rd_en, 0);
      end
      if (resp_valid) got_lat = n;
    end
    check("latency", got_lat, exp_lat);
    check("blk_1", blk_1, exp_blk[0]);
    check("blk_2", blk_2, exp_blk[1]);
    check("blk_3", blk_3, exp_blk[2]);
    check("blk_4", blk_4, exp_blk[3]);
    check("width", width, exp_w);
    check("height", height, exp_h);
    check("in_bounds", in_bounds, exp_inb);
    check("collide", collide, exp_col);
    saved = {blk_1, blk_2, blk_3, blk_4, width, height, in_bounds, collide};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", resp_valid, 1);
      check("hold_ready", req_ready, 0);
      check("hold_stable", {blk_1, blk_2, blk_3, blk_4, width, height, in_bounds, collide}, saved);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_dropped", resp_valid, 0);
  endtask

  initial begin
    int seen;
    build_shapes();
    for (int i = 0; i < W*H; i++) board[i] = 1'b0;

    // Reset held two cycles
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rd_en", brd_rd_en, 0);
    @(negedge clk);
    check("rst_resp_valid2", resp_valid, 0);
    check("rst_rd_en2", brd_rd_en, 0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);
    check("rst_blk_1", blk_1, ERR);
    check("rst_blk_4", blk_4, ERR);
    check("rst_wh", {width, height}, 0);
    check("rst_inb", in_bounds, 0);
    check("rst_col", collide, 0);
    check("rst_addr", brd_rd_addr, 0);

    // Directed cases
    do_req(3, 3, 0, 0, 0);          // T r0, empty board
    do_req(1, 7, 5, 1, 0);          // I r1 off the right edge
    board[191] = 1'b1;
    do_req(2, 0, 18, 0, 0);         // O touching occupied corner
    do_req(2, 0, 19, 0, 0);         // O off the bottom
    do_req(5, 8, 17, 1, 5);         // stall consumer five cycles
    do_req(0, 4, 4, 0, 0);          // EMPTY right after the handshake

    // Reset in the middle of a read sequence
    piece = 3'd3; pos_x = 4'd2; pos_y = 5'd4; rot = 2'd1;
    req_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) req_valid = 1'b0;
    end
    check("mid_rd_en", brd_rd_en, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_rd_en", brd_rd_en, 0);
    check("mid_rst_valid", resp_valid, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    check("mid_no_resp", seen, 0);

    // Randomized requests on randomized boards
    for (int t = 0; t < 60; t++) begin
      int p, x, y, r;
      for (int i = 0; i < W*H; i++) board[i] = ($urandom_range(3, 0) == 0);
      p = $urandom_range(7, 0);
      r = $urandom_range(3, 0);
      x = ($urandom_range(3, 0) != 0) ? $urandom_range(9, 0)  : $urandom_range(15, 0);
      y = ($urandom_range(3, 0) != 0) ? $urandom_range(19, 0) : $urandom_range(31, 0);
      do_req(p, x, y, r, $urandom_range(2, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
